pow2_gen: RTL
=============

Name: pow2_gen

Overview:
- Sequential power-of-two generator: accepts an exponent k and produces the W-bit one-hot value 2^k.
- Builds the value by shifting a single 1 left once per clock, so latency depends on k.
- Delivers the result with a valid/ack output handshake.
- Serves as the stimulus/producer end for the power-of-two detection logic in this area of the design: every non-error result it emits is, by construction, a power of two.

Parameters:
- W, 8, result width in bits.
- EW, 3, exponent input width; must satisfy 2^EW >= W.

Ports:
- clock  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; accepted only when ready=1.
- exp  input  EW  exponent k; sampled on the accepting edge only.
- ready  output  1  block idle and able to accept start.
- valid  output  1  result x (and err) valid, held until ack.
- ack  input  1  consumer acknowledges result; meaningful only while valid=1.
- x  output  W  result register, 2^k, LSB = bit 0.
- err  output  1  requested exponent out of range (k >= W); valid with x.

Behaviour:
- Single clock. Reset is synchronous and active-high: when reset=1 at a rising edge, all state returns to reset values regardless of other inputs.
- Reset values: state=IDLE, ready=1, valid=0, x=0, err=0, internal counter=0.
- States: IDLE, SHIFT, HOLD. ready=1 only in IDLE; valid=1 only in HOLD. Both are decoded from the state register, not combinational from inputs.
- IDLE, start=0: remain IDLE; x keeps its last value.
- IDLE, start=1 at edge T0, exp>=W: x<=0, err<=1, next state HOLD.
- IDLE, start=1 at edge T0, exp==0: x<=1, err<=0, next state HOLD.
- IDLE, start=1 at edge T0, 0<exp<W: x<=1, err<=0, cnt<=exp, next state SHIFT.
- SHIFT, each edge: x<=x<<1, cnt<=cnt-1. When cnt==1 at the edge, that same edge moves to HOLD.
- Result: exactly k shifts after T0, x=2^k.
- Latency: valid=1 after edge T0+k, i.e. k+1 edges after start is sampled. For k=0, valid=1 after T0. For out-of-range k, valid=1 after T0.
- HOLD: x and err are held stable.
  - ack=1 at an edge: next state IDLE, ready=1 after that edge. x is not cleared.
  - ack=0: remain HOLD indefinitely (backpressure).
- start while ready=0 (SHIFT or HOLD): ignored, with no effect on x, cnt or exp capture. Not queued.
- ack while valid=0: ignored.
- ack and start in the same HOLD cycle: ack honoured, start ignored. A new start is accepted no earlier than the cycle after ready returns to 1.
- Back-to-back: minimum issue interval is k+2 cycles (accept, k shifts, HOLD with ack in the same cycle, return to IDLE).
- Reset asserted during SHIFT or HOLD: abort, return to reset values next edge, no valid pulse.
- Invariant: whenever valid=1 and err=0, x has exactly one bit set, at position k.
- Invariant: valid=1 and err=1 implies x=0.
- No arithmetic overflow: cnt never decrements below 1 in SHIFT; x never shifts out its MSB because k<=W-1.

Test Plan:
- Reset: hold reset 2 cycles with start=1, exp=3 -> ready=1, valid=0, x=8'h00, err=0; no SHIFT entered.
- exp=0: pulse start -> valid=1 one edge later, x=8'h01, err=0; hold ack=0 for 5 cycles -> x stays 8'h01; ack=1 -> ready=1 next edge.
- exp=2 then exp=6 then exp=7, with ack asserted immediately each time -> x=8'h04, 8'h40, 8'h80; valid rises 3, 7, 8 edges after the respective start edge.
- Out-of-range with W=8, EW=4, exp=9 -> valid=1 after one edge, x=8'h00, err=1.
- Protocol: start pulsed with exp=1 during SHIFT of exp=5 -> result still x=8'h20. ack pulsed while valid=0 -> no effect. start+ack in the same HOLD cycle -> IDLE, no new job.
- Reset mid-SHIFT, exp=7, reset at 3rd shift edge -> x=8'h00, valid never asserted; a subsequent exp=3 job -> x=8'h08 with correct latency.

Source files
------------

// File: rtl/pow2_gen_if.sv
// Request/result bundle for the power-of-two generator.
// The master side is the generator. The slave side is whoever
// issues exponents and consumes results.
interface pow2_gen_if #(
  parameter int W  = 8,
  parameter int EW = 3
);
  logic          start;
  logic [EW-1:0] exp;
  logic          ready;
  logic          valid;
  logic          ack;
  logic [W-1:0]  x;
  logic          err;

  modport master (
    input  start,
    input  exp,
    input  ack,
    output ready,
    output valid,
    output x,
    output err
  );

  modport slave (
    output start,
    output exp,
    output ack,
    input  ready,
    input  valid,
    input  x,
    input  err
  );
endinterface

// File: rtl/pow2_gen.sv
// Sequential power-of-two generator.
// An accepted exponent k loads a single 1 into x. That bit is then shifted
// left once per clock for k clocks. The one-hot result 2^k is presented with
// a valid/ack handshake. An exponent k >= W yields x = 0 with err set.
module pow2_gen #(
  parameter int W  = 8,
  parameter int EW = 3
) (
  input  logic      clock,
  input  logic      reset,
  pow2_gen_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  // W widened by one bit, so that every EW-bit exponent compares cleanly against it.
  localparam logic [EW:0]   W_LIM   = (EW+1)'(W);
  localparam logic [W-1:0]  X_ONE   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]  X_ZERO  = {W{1'b0}};
  localparam logic [EW-1:0] CNT_ONE = {{(EW-1){1'b0}}, 1'b1};
  localparam logic [EW-1:0] CNT_ZERO = {EW{1'b0}};

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  x_q, x_d;
  logic          err_q, err_d;
  logic [EW-1:0] cnt_q, cnt_d;
  logic [EW:0]   exp_wide;

  assign exp_wide = {1'b0, bus.exp};

  // Handshake flags are decoded purely from the state register.
  assign bus.ready = (state_q == S_IDLE);
  assign bus.valid = (state_q == S_HOLD);
  assign bus.x     = x_q;
  assign bus.err   = err_q;

  // Next-state logic for the IDLE -> SHIFT -> HOLD sequence and the shifting datapath.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (exp_wide >= W_LIM) begin
            // Out of range: the result is zero, and it is flagged as an error immediately.
            x_d     = X_ZERO;
            err_d   = 1'b1;
            state_d = S_HOLD;
          end else if (bus.exp == CNT_ZERO) begin
            x_d     = X_ONE;
            err_d   = 1'b0;
            state_d = S_HOLD;
          end else begin
            x_d     = X_ONE;
            err_d   = 1'b0;
            cnt_d   = bus.exp;
            state_d = S_SHIFT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        // cnt holds the number of shifts still owed, including this one.
        x_d   = {x_q[W-2:0], 1'b0};
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_HOLD;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_HOLD: begin
        // While HOLD lasts, start is ignored. Only ack releases the result.
        if (bus.ack) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
        x_d     = X_ZERO;
        err_d   = 1'b0;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= X_ZERO;
      err_q   <= 1'b0;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
